// File: rtl/mem_stage.sv
// mem_stage -- MEM stage of the 5-stage RV32I pipeline.
//
// Purpose:
//   ALU-type instructions pass from EX/MEM to MEM/WB with zero latency.
//   Loads and stores are split into little-endian byte transfers on an 8-bit
//   req/ack data-memory port. While a transfer sequence runs, stall_MEM_o
//   holds the upstream pipeline registers so the EX/MEM inputs stay stable.
//
// Ports:
//   dclk, rst             clock, asynchronous active-high reset
//   aluop_MEM_i           operation code (`AluOpBus)
//   wreg_MEM_i            register-write enable
//   waddr_MEM_i           destination register
//   alurslt_MEM_i         ALU result / effective byte address
//   storedata_MEM_i       store data (rs2)
//   mem_req_o/_we_o       byte transfer request / write strobe
//   mem_addr_o            byte address (low MEM_ADDR_W bits)
//   mem_wdata_o           write byte
//   mem_rdata_i/_ack_i    read byte / transfer complete
//   stall_MEM_o           hold IF/ID/EX and EX/MEM registers
//   wreg_WB_o, waddr_WB_o, wdata_WB_o   to MEM/WB
//   state_dbg_o           current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
//
// Memory handshake: mem_req_o rises and stays high until the last byte of
// the sequence is acknowledged. A transfer completes on every dclk edge where
// mem_req_o and mem_ack_i are both high; ack may arrive in the same cycle as
// req. Address, write strobe and write byte only change on an acked edge.

`ifndef MEM_STAGE_ALU_OPS
`define MEM_STAGE_ALU_OPS
`define AluOpBus   7:0
`define ALU_NOP_OP 8'h00
`define ALU_ADD_OP 8'h20
`define ALU_LB_OP  8'hE0
`define ALU_LH_OP  8'hE1
`define ALU_LW_OP  8'hE3
`define ALU_LBU_OP 8'hE4
`define ALU_LHU_OP 8'hE5
`define ALU_SB_OP  8'hE8
`define ALU_SH_OP  8'hE9
`define ALU_SW_OP  8'hEB
`endif

module mem_stage #(
   parameter int MEM_ADDR_W = 17
) (
   input  logic                  dclk,
   input  logic                  rst,
   input  logic [`AluOpBus]      aluop_MEM_i,
   input  logic                  wreg_MEM_i,
   input  logic [4:0]            waddr_MEM_i,
   input  logic [31:0]           alurslt_MEM_i,
   input  logic [31:0]           storedata_MEM_i,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [MEM_ADDR_W-1:0] mem_addr_o,
   output logic [7:0]            mem_wdata_o,
   input  logic [7:0]            mem_rdata_i,
   input  logic                  mem_ack_i,
   output logic                  stall_MEM_o,
   output logic                  wreg_WB_o,
   output logic [4:0]            waddr_WB_o,
   output logic [31:0]           wdata_WB_o,
   output logic [1:0]            state_dbg_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   state_e                state_q;
   logic [1:0]            k_q;
   logic [31:0]           buf_q;
   logic                  mem_req_q;
   logic                  mem_we_q;
   logic [MEM_ADDR_W-1:0] mem_addr_q;
   logic [7:0]            mem_wdata_q;

   // Decode of the held EX/MEM operation.
   logic       is_mem;
   logic       is_store;
   logic [1:0] last_k;     // N-1
   logic [1:0] k_d;
   logic [31:0] load_word;

   always_comb begin
      is_mem   = 1'b0;
      is_store = 1'b0;
      last_k   = 2'd0;
      case (aluop_MEM_i)
         `ALU_LB_OP, `ALU_LBU_OP: begin is_mem = 1'b1; last_k = 2'd0; end
         `ALU_LH_OP, `ALU_LHU_OP: begin is_mem = 1'b1; last_k = 2'd1; end
         `ALU_LW_OP:              begin is_mem = 1'b1; last_k = 2'd3; end
         `ALU_SB_OP: begin is_mem = 1'b1; is_store = 1'b1; last_k = 2'd0; end
         `ALU_SH_OP: begin is_mem = 1'b1; is_store = 1'b1; last_k = 2'd1; end
         `ALU_SW_OP: begin is_mem = 1'b1; is_store = 1'b1; last_k = 2'd3; end
         default: ;
      endcase
   end

   assign k_d = k_q + 2'd1;

   // Load result formatting; stores and non-memory ops give zero.
   always_comb begin
      load_word = 32'h0;
      case (aluop_MEM_i)
         `ALU_LB_OP:  load_word = {{24{buf_q[7]}}, buf_q[7:0]};
         `ALU_LBU_OP: load_word = {24'h0, buf_q[7:0]};
         `ALU_LH_OP:  load_word = {{16{buf_q[15]}}, buf_q[15:0]};
         `ALU_LHU_OP: load_word = {16'h0, buf_q[15:0]};
         `ALU_LW_OP:  load_word = buf_q;
         default:     load_word = 32'h0;
      endcase
   end

   // Stall and MEM/WB outputs are combinational so ALU ops see zero latency.
   always_comb begin
      stall_MEM_o = 1'b0;
      wreg_WB_o   = 1'b0;
      waddr_WB_o  = 5'd0;
      wdata_WB_o  = 32'h0;
      case (state_q)
         S_IDLE: begin
            if (is_mem) begin
               stall_MEM_o = 1'b1;   // bubble while the access is set up
            end else begin
               wreg_WB_o  = wreg_MEM_i;
               waddr_WB_o = waddr_MEM_i;
               wdata_WB_o = alurslt_MEM_i;
            end
         end
         S_ACCESS: stall_MEM_o = 1'b1;
         S_DONE: begin
            wreg_WB_o  = wreg_MEM_i;
            waddr_WB_o = waddr_MEM_i;
            wdata_WB_o = load_word;
         end
         default: ;
      endcase
   end

   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         k_q         <= 2'd0;
         buf_q       <= 32'h0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (is_mem) begin
                  state_q     <= S_ACCESS;
                  k_q         <= 2'd0;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= is_store;
                  mem_addr_q  <= alurslt_MEM_i[MEM_ADDR_W-1:0];
                  mem_wdata_q <= storedata_MEM_i[7:0];
               end
            end
            S_ACCESS: begin
               if (mem_ack_i) begin
                  if (!is_store) begin
                     buf_q[{k_q, 3'b000} +: 8] <= mem_rdata_i;
                  end
                  if (k_q == last_k) begin
                     mem_req_q <= 1'b0;
                     mem_we_q  <= 1'b0;
                     state_q   <= S_DONE;
                  end else begin
                     k_q         <= k_d;
                     // base + k + 1, wrapping within the memory address space
                     mem_addr_q  <= alurslt_MEM_i[MEM_ADDR_W-1:0]
                                    + {{(MEM_ADDR_W-2){1'b0}}, k_d};
                     mem_wdata_q <= storedata_MEM_i[{k_d, 3'b000} +: 8];
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               k_q     <= 2'd0;
               buf_q   <= 32'h0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed, table-driven bench for mem_stage.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge. A small byte-memory model answers the req/ack port with a
// programmable number of wait cycles per byte.

`ifndef MEM_STAGE_ALU_OPS
`define MEM_STAGE_ALU_OPS
`define AluOpBus   7:0
`define ALU_NOP_OP 8'h00
`define ALU_ADD_OP 8'h20
`define ALU_LB_OP  8'hE0
`define ALU_LH_OP  8'hE1
`define ALU_LW_OP  8'hE3
`define ALU_LBU_OP 8'hE4
`define ALU_LHU_OP 8'hE5
`define ALU_SB_OP  8'hE8
`define ALU_SH_OP  8'hE9
`define ALU_SW_OP  8'hEB
`endif

module tb_mem_stage;
   localparam int AW = 17;

   // ---------------- clock / reset / DUT ----------------
   logic          dclk = 1'b0;
   logic          rst;
   logic [7:0]    aluop;
   logic          wreg;
   logic [4:0]    waddr;
   logic [31:0]   alurslt;
   logic [31:0]   storedata;
   logic          mem_req, mem_we, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata, mem_rdata;
   logic          stall, wreg_wb;
   logic [4:0]    waddr_wb;
   logic [31:0]   wdata_wb;
   logic [1:0]    state_dbg;

   always #5 dclk = ~dclk;

   mem_stage #(.MEM_ADDR_W(AW)) dut (
      .dclk(dclk), .rst(rst),
      .aluop_MEM_i(aluop), .wreg_MEM_i(wreg), .waddr_MEM_i(waddr),
      .alurslt_MEM_i(alurslt), .storedata_MEM_i(storedata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
      .stall_MEM_o(stall), .wreg_WB_o(wreg_wb), .waddr_WB_o(waddr_wb),
      .wdata_WB_o(wdata_wb), .state_dbg_o(state_dbg)
   );

   // ---------------- memory model ----------------
   logic [7:0]  rom [0:4095];
   int unsigned ack_delay = 0;
   int unsigned wait_cnt;
   int          ack_cnt = 0;
   logic [24:0] obs_q[$];     // observed writes {addr, byte}

   assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
   assign mem_rdata = mem_ack ? rom[mem_addr[11:0]] : 8'h00;

   always @(posedge dclk or posedge rst) begin
      if (rst) wait_cnt <= 0;
      else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   always @(posedge dclk) begin
      if (!rst && mem_ack) begin
         ack_cnt <= ack_cnt + 1;
         if (mem_we) obs_q.push_back({mem_addr, mem_wdata});
      end
   end

   // ---------------- scoreboard ----------------
   int          errors = 0;
   int          checks = 0;
   int          rd_ptr = 0;
   logic [24:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_store(input logic [31:0] addr, input logic [31:0] data, input int nb);
      for (int i = 0; i < nb; i++) begin
         logic [AW-1:0] a;
         a = addr[AW-1:0] + AW'(i);
         exp_q.push_back({a, data[8*i +: 8]});
      end
   endtask

   task automatic check_writes(input string tag);
      logic [24:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd_ptr < obs_q.size()) begin
            chk({tag, "_wr"}, 32'(obs_q[rd_ptr]), 32'(e));
            rd_ptr++;
         end else begin
            checks++;
            errors++;
            $display("FAIL %s_wr_missing: got none expected 0x%07h", tag, e);
         end
      end
      chk({tag, "_wr_count"}, 32'(obs_q.size()), 32'(rd_ptr));
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [7:0] op, input logic w, input logic [4:0] wa,
                        input logic [31:0] r, input logic [31:0] sd);
      aluop = op; wreg = w; waddr = wa; alurslt = r; storedata = sd;
   endtask

   // Runs one memory op starting in IDLE; returns one cycle after DONE.
   task automatic run_op(input string tag, input logic [7:0] op, input logic w,
                         input logic [4:0] wa, input logic [31:0] addr,
                         input logic [31:0] sd, input int delay, input int nb,
                         input logic [31:0] exp_wdata);
      int          cnt, start_ack, prev_ack, hold_bad, bubble_bad;
      bit          done, have_prev;
      logic [25:0] prev_port;
      ack_delay = delay;
      drive(op, w, wa, addr, sd);
      start_ack = ack_cnt;
      cnt = 0; hold_bad = 0; bubble_bad = 0; done = 0; have_prev = 0;
      prev_ack = 0; prev_port = '0;
      for (int c = 0; c < 300; c++) begin
         @(negedge dclk);
         if (!stall) begin done = 1; break; end
         cnt++;
         if (wreg_wb || waddr_wb != 5'd0 || wdata_wb != 32'h0) bubble_bad++;
         if (have_prev && ack_cnt == prev_ack && {mem_we, mem_addr, mem_wdata} !== prev_port)
            hold_bad++;
         prev_port = {mem_we, mem_addr, mem_wdata};
         prev_ack  = ack_cnt;
         have_prev = (state_dbg == 2'd1);
         @(posedge dclk); #1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: stall still high after 300 cycles", tag);
      end else begin
         chk({tag, "_stall_cycles"}, 32'(cnt), 32'(1 + nb * (delay + 1)));
         chk({tag, "_done_state"}, 32'(state_dbg), 32'd2);
         chk({tag, "_wdata"}, wdata_wb, exp_wdata);
         chk({tag, "_wreg"}, 32'(wreg_wb), 32'(w));
         chk({tag, "_waddr"}, 32'(waddr_wb), 32'(wa));
         chk({tag, "_req_low"}, 32'(mem_req), 32'd0);
         chk({tag, "_acks"}, 32'(ack_cnt - start_ack), 32'(nb));
         chk({tag, "_bubble"}, 32'(bubble_bad), 32'd0);
         chk({tag, "_hold"}, 32'(hold_bad), 32'd0);
      end
      @(posedge dclk); #1;
   endtask

   // ---------------- vector tables ----------------
   typedef struct {
      logic [7:0]  op;
      logic        w;
      logic [4:0]  wa;
      logic [31:0] r;
      logic        exp_wreg;
      logic [4:0]  exp_waddr;
      logic [31:0] exp_wdata;
   } alu_vec_t;

   typedef struct {
      string       tag;
      logic [7:0]  op;
      logic        w;
      logic [4:0]  wa;
      logic [31:0] addr;
      logic [31:0] sd;
      int          delay;
      int          nb;
      logic [31:0] exp_wdata;
   } mem_vec_t;

   alu_vec_t alu_tab[3];
   mem_vec_t mem_tab[8];

   initial begin
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
      rom[12'h200] = 8'h80; rom[12'h201] = 8'h7F;
      rom[12'h202] = 8'hFE; rom[12'h203] = 8'hFF;
      rom[12'h400] = 8'h01; rom[12'h401] = 8'h82;
      rom[12'h402] = 8'h43; rom[12'h403] = 8'hC4;

      alu_tab[0] = '{`ALU_ADD_OP, 1'b1, 5'd5,  32'h12345678, 1'b1, 5'd5,  32'h12345678};
      alu_tab[1] = '{8'h25,       1'b0, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd31, 32'hFFFFFFFF};
      alu_tab[2] = '{8'h21,       1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};

      mem_tab[0] = '{"sw",     `ALU_SW_OP,  1'b0, 5'd0, 32'h100, 32'hAABBCCDD, 0, 4, 32'h0};
      mem_tab[1] = '{"lb",     `ALU_LB_OP,  1'b1, 5'd7, 32'h200, 32'h0, 0, 1, 32'hFFFFFF80};
      mem_tab[2] = '{"lbu",    `ALU_LBU_OP, 1'b1, 5'd8, 32'h200, 32'h0, 0, 1, 32'h00000080};
      mem_tab[3] = '{"lh",     `ALU_LH_OP,  1'b1, 5'd9, 32'h200, 32'h0, 0, 2, 32'h00007F80};
      mem_tab[4] = '{"lhu_neg",`ALU_LHU_OP, 1'b1, 5'd10, 32'h202, 32'h0, 0, 2, 32'h0000FFFE};
      mem_tab[5] = '{"lh_mis", `ALU_LH_OP,  1'b1, 5'd11, 32'h201, 32'h0, 0, 2, 32'hFFFFFE7F};
      mem_tab[6] = '{"lw_wait",`ALU_LW_OP,  1'b1, 5'd12, 32'h400, 32'h0, 3, 4, 32'hC4438201};
      mem_tab[7] = '{"sh_wrap",`ALU_SH_OP,  1'b0, 5'd0, 32'h0001FFFF, 32'h0000BEEF, 1, 2, 32'h0};

      // ---- reset state ----
      rst = 1'b1;
      drive(`ALU_NOP_OP, 1'b0, 5'd0, 32'h0, 32'h0);
      repeat (2) @(posedge dclk);
      @(negedge dclk);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata_mem", 32'(mem_wdata), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wb", {wreg_wb, waddr_wb, 26'h0}, 32'h0);
      chk("rst_wdata_wb", wdata_wb, 32'h0);
      chk("rst_state", 32'(state_dbg), 32'd0);
      @(posedge dclk); #1;
      rst = 1'b0;

      // ---- ALU pass-through, zero latency ----
      for (int i = 0; i < 3; i++) begin
         drive(alu_tab[i].op, alu_tab[i].w, alu_tab[i].wa, alu_tab[i].r, 32'h5555AAAA);
         @(negedge dclk);
         chk($sformatf("alu%0d_wdata", i), wdata_wb, alu_tab[i].exp_wdata);
         chk($sformatf("alu%0d_wreg", i), 32'(wreg_wb), 32'(alu_tab[i].exp_wreg));
         chk($sformatf("alu%0d_waddr", i), 32'(waddr_wb), 32'(alu_tab[i].exp_waddr));
         chk($sformatf("alu%0d_stall", i), 32'(stall), 32'd0);
         chk($sformatf("alu%0d_req", i), 32'(mem_req), 32'd0);
         @(posedge dclk); #1;
      end
      chk("alu_no_acks", 32'(ack_cnt), 32'd0);

      // ---- memory op table ----
      for (int i = 0; i < 8; i++) begin
         if (mem_tab[i].op == `ALU_SB_OP || mem_tab[i].op == `ALU_SH_OP ||
             mem_tab[i].op == `ALU_SW_OP)
            push_store(mem_tab[i].addr, mem_tab[i].sd, mem_tab[i].nb);
         run_op(mem_tab[i].tag, mem_tab[i].op, mem_tab[i].w, mem_tab[i].wa,
                mem_tab[i].addr, mem_tab[i].sd, mem_tab[i].delay, mem_tab[i].nb,
                mem_tab[i].exp_wdata);
         check_writes(mem_tab[i].tag);
      end

      // ---- LW immediately followed by SB ----
      run_op("b2b_lw", `ALU_LW_OP, 1'b1, 5'd13, 32'h400, 32'h0, 0, 4, 32'hC4438201);
      push_store(32'h500, 32'h1234565A, 1);
      run_op("b2b_sb", `ALU_SB_OP, 1'b0, 5'd0, 32'h500, 32'h1234565A, 0, 1, 32'h0);
      check_writes("b2b");

      // ---- reset during byte 2 of an SW ----
      ack_delay = 0;
      drive(`ALU_SW_OP, 1'b0, 5'd0, 32'h300, 32'h11223344);
      @(posedge dclk);          // enter ACCESS, byte 0 on the port
      @(posedge dclk); #1;      // byte 0 written, byte 1 now on the port
      chk("mid_k1_addr", 32'(mem_addr), 32'h301);
      rst = 1'b1;
      drive(`ALU_NOP_OP, 1'b0, 5'd0, 32'h0, 32'h0);
      #1;
      chk("mid_rst_req", 32'(mem_req), 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      chk("mid_rst_state", 32'(state_dbg), 32'd0);
      chk("mid_rst_addr", 32'(mem_addr), 32'd0);
      exp_q.push_back({17'h300, 8'h44});
      @(negedge dclk);
      @(posedge dclk); #1;
      rst = 1'b0;
      check_writes("mid_rst");
      push_store(32'h600, 32'h00000077, 1);
      run_op("post_rst_sb", `ALU_SB_OP, 1'b0, 5'd0, 32'h600, 32'h00000077, 0, 1, 32'h0);
      check_writes("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
